// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES bus masters.
// Holds the OAM DMA state encoding, the register addresses and the CPU page width.
package nes_bus_pkg;

    localparam int CPU_PAGE_W = 8;

    localparam logic [15:0] CPU_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] PPU_OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_e;

endpackage

// File: rtl/cpu_cycle_parity.sv
// CPU cycle parity tracker: one flop toggled at the end of every CPU cycle.
// Ports: clk, rst (async, active-high), ph2_falling in; get_cycle out.
// get_cycle=1 while the current CPU cycle is a get (even) cycle.
module cpu_cycle_parity (
    input  logic clk,
    input  logic rst,
    input  logic ph2_falling,
    output logic get_cycle
);

    logic parity_q;
    logic parity_d;

    always_comb begin
        parity_d = parity_q;
        if (ph2_falling) begin
            parity_d = ~parity_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign get_cycle = ~parity_q;

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: CPU-bus master between the 6502 core and the memory manager.
// A write to DMA_REG_ADDR halts the CPU (cpu_rdy=0) and copies BYTE_COUNT bytes
// from page {cpu_data_in,00} to OAM_DATA_ADDR; when idle the CPU bus passes through.
// Ports: clk, rst (async, active-high), ph2_falling, cpu_addr/cpu_rnw/cpu_data_in,
// mem_data_in in; bus_addr/bus_rnw/bus_data_out, cpu_rdy, dma_active out.
// Build option: OAM_DMA_ODD_ALIGN_EN inserts an ALIGN cycle when HALT is followed
// by a put cycle (2A03 timing, 514-cycle transfers).
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = CPU_DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAM_DATA_ADDR,
    parameter int          BYTE_COUNT    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_rnw,
    output logic [7:0]  bus_data_out,
    output logic        cpu_rdy,
    output logic        dma_active
);

    localparam logic [CPU_PAGE_W-1:0] LAST_IDX = CPU_PAGE_W'(BYTE_COUNT - 1);

    dma_state_e            state_q, state_d;
    logic [CPU_PAGE_W-1:0] page_q, page_d;
    logic [CPU_PAGE_W-1:0] idx_q, idx_d;
    logic [7:0]            data_latch_q, data_latch_d;
    logic                  rdy_q, rdy_d;
    logic                  active_q, active_d;

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic get_cycle;

    cpu_cycle_parity u_parity (
        .clk         (clk),
        .rst         (rst),
        .ph2_falling (ph2_falling),
        .get_cycle   (get_cycle)
    );
`endif

    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        idx_d        = idx_q;
        data_latch_d = data_latch_q;
        rdy_d        = rdy_q;
        active_d     = active_q;
        if (ph2_falling) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cpu_addr == DMA_REG_ADDR && !cpu_rnw && rdy_q) begin
                        state_d  = ST_HALT;
                        page_d   = cpu_data_in;
                        idx_d    = '0;
                        rdy_d    = 1'b0;
                        active_d = 1'b1;
                    end
                end
                ST_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                    // HALT being a get cycle means the next one is a put
                    // cycle, so burn one cycle to start READ on a get.
                    state_d = get_cycle ? ST_ALIGN : ST_READ;
`else
                    state_d = ST_READ;
`endif
                end
                ST_ALIGN: begin
                    state_d = ST_READ;
                end
                ST_READ: begin
                    state_d      = ST_WRITE;
                    data_latch_d = mem_data_in;
                end
                ST_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_IDLE;
                        idx_d    = '0;
                        rdy_d    = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        state_d = ST_READ;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    rdy_d    = 1'b1;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            page_q       <= '0;
            idx_q        <= '0;
            data_latch_q <= '0;
            rdy_q        <= 1'b1;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            idx_q        <= idx_d;
            data_latch_q <= data_latch_d;
            rdy_q        <= rdy_d;
            active_q     <= active_d;
        end
    end

    always_comb begin
        bus_addr     = cpu_addr;
        bus_rnw      = cpu_rnw;
        bus_data_out = cpu_data_in;
        unique case (state_q)
            ST_IDLE: begin
                bus_rnw = cpu_rnw;
            end
            ST_HALT, ST_ALIGN: begin
                bus_rnw = 1'b1;
            end
            ST_READ: begin
                bus_addr = {page_q, idx_q};
                bus_rnw  = 1'b1;
            end
            ST_WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_rnw      = 1'b0;
                bus_data_out = data_latch_q;
            end
            default: begin
                bus_rnw = cpu_rnw;
            end
        endcase
    end

    assign cpu_rdy    = rdy_q;
    assign dma_active = active_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: pass-through vector table plus
// directed DMA sequences (alignment, page $FF, reset mid-transfer, stray trigger).
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ph2_falling;
    logic [15:0] cpu_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_data_in;
    logic [7:0]  mem_data_in;
    logic [15:0] bus_addr;
    logic        bus_rnw;
    logic [7:0]  bus_data_out;
    logic        cpu_rdy;
    logic        dma_active;

    localparam logic [15:0] IDLE_A = 16'h5555;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ph2_falling  (ph2_falling),
        .cpu_addr     (cpu_addr),
        .cpu_rnw      (cpu_rnw),
        .cpu_data_in  (cpu_data_in),
        .mem_data_in  (mem_data_in),
        .bus_addr     (bus_addr),
        .bus_rnw      (bus_rnw),
        .bus_data_out (bus_data_out),
        .cpu_rdy      (cpu_rdy),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    // One CPU cycle every three clocks.
    logic [1:0] phcnt = 2'd0;
    always @(posedge clk) phcnt <= (phcnt == 2'd2) ? 2'd0 : phcnt + 2'd1;
    assign ph2_falling = (phcnt == 2'd2);

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        else if (a[15]) return a[7:0] ^ a[15:8] ^ 8'h3C;
        else return a[7:0] ^ 8'h11;
    endfunction

    assign mem_data_in = mem_rd(bus_addr);

    // Bus monitor, sampled mid-clock ahead of each ph2_falling edge.
    int         pulses = 0;
    int         hcnt = 0;
    logic [7:0]  wlog[$];
    logic [15:0] rlog[$];

    always @(negedge clk) begin
        if (rst) begin
            pulses <= 0;
        end else if (ph2_falling) begin
            pulses <= pulses + 1;
            if (!cpu_rdy) hcnt <= hcnt + 1;
            if (dma_active && !bus_rnw && bus_addr == 16'h2004)
                wlog.push_back(bus_data_out);
            if (dma_active && bus_rnw && bus_addr != cpu_addr)
                rlog.push_back(bus_addr);
        end
    end

    int nerr = 0;
    int nchk = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cpu_cyc(input logic [15:0] a, input logic rnw,
                           input logic [7:0] d);
        cpu_addr    = a;
        cpu_rnw     = rnw;
        cpu_data_in = d;
        @(negedge clk);
        while (!ph2_falling) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_dma(input logic [7:0] page, input bit stray,
                          output int par);
        int wb, rb, hb, n, exp_len, wn, rn;
        logic [15:0] ea;
        wb = wlog.size();
        rb = rlog.size();
        hb = hcnt;
        cpu_cyc(16'h4014, 1'b0, page);
        par = pulses & 1;
        check("halt_rdy", cpu_rdy, 0);
        check("halt_active", dma_active, 1);
        check("halt_rnw", bus_rnw, 1);
        check("halt_addr", bus_addr, 16'h4014);
        n = 0;
        while (n < 2000 && !cpu_rdy) begin
            if (stray && (n == 10 || n == 11))
                cpu_cyc(16'h4014, 1'b0, 8'h33);
            else
                cpu_cyc(IDLE_A, 1'b1, 8'h00);
            n++;
        end
        check("dma_done_rdy", cpu_rdy, 1);
        check("dma_done_active", dma_active, 0);
        exp_len = 513;
`ifdef OAM_DMA_ODD_ALIGN_EN
        if (par == 0) exp_len = 514;
`endif
        check("halt_len", hcnt - hb, exp_len);
        wn = wlog.size() - wb;
        rn = rlog.size() - rb;
        check("write_count", wn, 256);
        check("read_count", rn, 256);
        for (int i = 0; i < 256 && i < wn && i < rn; i++) begin
            ea = {page, 8'(i)};
            check("read_addr", rlog[rb+i], ea);
            check("write_data", wlog[wb+i], mem_rd(ea));
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic        rnw;
        logic [7:0]  d;
        logic [15:0] ea;
        logic        erw;
        logic [7:0]  ed;
    } vec_t;

    vec_t vt[5];

    initial begin
        int p1, p2, p, wb, n;
        vt[0] = '{16'h8000, 1'b1, 8'h00, 16'h8000, 1'b1, 8'h00};
        vt[1] = '{16'h0005, 1'b0, 8'h3C, 16'h0005, 1'b0, 8'h3C};
        vt[2] = '{16'h4014, 1'b1, 8'h02, 16'h4014, 1'b1, 8'h02};
        vt[3] = '{16'h4015, 1'b0, 8'h02, 16'h4015, 1'b0, 8'h02};
        vt[4] = '{16'h2004, 1'b0, 8'h77, 16'h2004, 1'b0, 8'h77};

        rst         = 1'b1;
        cpu_addr    = 16'h1234;
        cpu_rnw     = 1'b0;
        cpu_data_in = 8'h5A;
        repeat (4) @(posedge clk);
        #1;
        check("rst_rdy", cpu_rdy, 1);
        check("rst_active", dma_active, 0);
        check("rst_addr", bus_addr, 16'h1234);
        check("rst_rnw", bus_rnw, 0);
        check("rst_data", bus_data_out, 8'h5A);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cpu_addr    = vt[i].a;
            cpu_rnw     = vt[i].rnw;
            cpu_data_in = vt[i].d;
            #1;
            check("pt_addr", bus_addr, vt[i].ea);
            check("pt_rnw", bus_rnw, vt[i].erw);
            check("pt_data", bus_data_out, vt[i].ed);
            check("pt_rdy", cpu_rdy, 1);
            check("pt_active", dma_active, 0);
            cpu_cyc(vt[i].a, vt[i].rnw, vt[i].d);
        end
        check("pt_rdy_end", cpu_rdy, 1);

        do_dma(8'h02, 1'b0, p1);

        while ((pulses & 1) != p1) cpu_cyc(IDLE_A, 1'b1, 8'h00);
        do_dma(8'h02, 1'b0, p2);
        check("parity_covered", p1 != p2, 1);

        do_dma(8'hFF, 1'b0, p);

        wb = wlog.size();
        cpu_cyc(16'h4014, 1'b0, 8'h02);
        n = 0;
        while (n < 1000 && (wlog.size() - wb) < 100) begin
            cpu_cyc(IDLE_A, 1'b1, 8'h00);
            n++;
        end
        check("mid_writes", wlog.size() - wb, 100);
        check("mid_addr", bus_addr, 16'h0264);
        cpu_addr    = 16'h0123;
        cpu_rnw     = 1'b0;
        cpu_data_in = 8'h99;
        #3;
        rst = 1'b1;
        #1;
        check("mrst_rdy", cpu_rdy, 1);
        check("mrst_active", dma_active, 0);
        check("mrst_addr", bus_addr, 16'h0123);
        check("mrst_rnw", bus_rnw, 0);
        check("mrst_data", bus_data_out, 8'h99);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_cyc(IDLE_A, 1'b1, 8'h00);
        check("post_rst_rdy", cpu_rdy, 1);
        do_dma(8'h02, 1'b0, p);

        do_dma(8'h02, 1'b1, p);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
